// File: rtl/spike_dispatch_pkg.sv
// Shared definitions for the spike dispatch scheduler: FSM state encoding,
// default table widths, and helpers that locate fields in the flattened
// CSR table vectors.
package spike_dispatch_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIntegrate,
    StCapture,
    StSelect,
    StEmit
  } state_e;

  localparam int unsigned DefaultAddrW = 12;
  localparam int unsigned DefaultPtrW  = 5;

  // LSB of ptr[i]; ptr[0] sits in the most significant field.
  function automatic int unsigned ptr_lsb(input int unsigned num_neurons,
                                          input int unsigned ptr_w,
                                          input int unsigned i);
    return (num_neurons - i) * ptr_w;
  endfunction

  // LSB of entry[k]; entry[0] sits in the most significant field.
  function automatic int unsigned entry_lsb(input int unsigned max_conn,
                                            input int unsigned addr_w,
                                            input int unsigned k);
    return (max_conn - 1 - k) * addr_w;
  endfunction

endpackage

// File: rtl/spike_dispatch_scheduler_arbiter.sv
// Pending-neuron arbiter. Default build is fixed priority (lowest index
// first); with SPIKE_DISPATCH_RR_EN defined the search starts at rr_ptr.
module spike_pending_arbiter #(
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned IDX_W       = 4
) (
  input  logic [NUM_NEURONS-1:0] pending,
  input  logic [IDX_W-1:0]       rr_ptr,
  output logic [IDX_W-1:0]       grant,
  output logic                   any_pending
);

`ifndef SPIKE_DISPATCH_RR_EN
  logic unused_rr_ptr;
  assign unused_rr_ptr = ^rr_ptr;
`endif

  // Scan the mask from the start position, wrapping, and take the first hit.
  always_comb begin
    int unsigned start;
    int unsigned j;
    grant       = '0;
    any_pending = 1'b0;
`ifdef SPIKE_DISPATCH_RR_EN
    start = 32'(rr_ptr);
`else
    start = 0;
`endif
    for (int unsigned off = 0; off < NUM_NEURONS; off++) begin
      j = start + off;
      if (j >= NUM_NEURONS) j = j - NUM_NEURONS;
      if (!any_pending && pending[j]) begin
        any_pending = 1'b1;
        grant       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spike_dispatch_scheduler.sv
// Timestep controller and spike fan-out scheduler. Paces timesteps with a
// one-cycle clear pulse, latches the spike vector, then walks the CSR tables
// emitting one (origin, destination) packet per downstream connection.
// Optional feature macro: SPIKE_DISPATCH_RR_EN (round-robin neuron selection).
module spike_dispatch_scheduler
  import spike_dispatch_pkg::*;
#(
  parameter int unsigned NUM_NEURONS     = 10,
  parameter int unsigned ADDR_W          = DefaultAddrW,
  parameter int unsigned PTR_W           = DefaultPtrW,
  parameter int unsigned MAX_CONN        = 30,
  parameter int unsigned TIMESTEP_CYCLES = 4
) (
  input  logic                             CLK,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_NEURONS-1:0]           spike,
  input  logic [NUM_NEURONS*ADDR_W-1:0]    neuron_addresses_initialization,
  input  logic [(NUM_NEURONS+1)*PTR_W-1:0] connection_pointer_initialization,
  input  logic [MAX_CONN*ADDR_W-1:0]       downstream_connections_initialization,
  output logic                             clear,
  output logic                             pkt_valid,
  input  logic                             pkt_ready,
  output logic [ADDR_W-1:0]                pkt_origin,
  output logic [ADDR_W-1:0]                pkt_destination,
  output logic                             busy,
  output logic [15:0]                      timestep_count
);

  localparam int unsigned IdxW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned CycW  = (TIMESTEP_CYCLES > 1) ? $clog2(TIMESTEP_CYCLES) : 1;
  localparam int unsigned ConnW = $clog2(MAX_CONN + 1);
  // Wide enough for any pointer, MAX_CONN itself, and idx+1 without overflow.
  localparam int unsigned PosW  = ((ConnW > PTR_W) ? ConnW : PTR_W) + 1;
  localparam logic [PosW-1:0] MaxConnPos = PosW'(MAX_CONN);

  state_e                 state_q, state_d;
  logic [CycW-1:0]        cyc_q, cyc_d;
  logic [NUM_NEURONS-1:0] mask_q, mask_d;
  logic [IdxW-1:0]        rr_q, rr_d;
  logic [IdxW-1:0]        cur_q, cur_d;
  logic [PosW-1:0]        idx_q, idx_d;
  logic [PosW-1:0]        end_q, end_d;
  logic [ADDR_W-1:0]      origin_q, origin_d;
  logic [ADDR_W-1:0]      dest_q, dest_d;
  logic [15:0]            ts_q, ts_d;

  logic [IdxW-1:0] grant;
  logic            any_pending;
  logic [PosW-1:0] sel_start;
  logic [PosW-1:0] sel_limit;

  function automatic logic [PosW-1:0] ptr_at(input int unsigned i);
    return PosW'(connection_pointer_initialization[ptr_lsb(NUM_NEURONS, PTR_W, i) +: PTR_W]);
  endfunction

  // Out-of-table lookups return zero; they only occur on paths whose result is discarded.
  function automatic logic [ADDR_W-1:0] entry_at(input logic [PosW-1:0] k);
    if (32'(k) < MAX_CONN) begin
      return downstream_connections_initialization[entry_lsb(MAX_CONN, ADDR_W, 32'(k)) +: ADDR_W];
    end
    return '0;
  endfunction

  function automatic logic [ADDR_W-1:0] addr_at(input logic [IdxW-1:0] i);
    return neuron_addresses_initialization[32'(i) * ADDR_W +: ADDR_W];
  endfunction

  spike_pending_arbiter #(
    .NUM_NEURONS (NUM_NEURONS),
    .IDX_W       (IdxW)
  ) u_arbiter (
    .pending     (mask_q),
    .rr_ptr      (rr_q),
    .grant       (grant),
    .any_pending (any_pending)
  );

  // Next-state logic for the timestep/dispatch FSM and its datapath.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    mask_d   = mask_q;
    rr_d     = rr_q;
    cur_d    = cur_q;
    idx_d    = idx_q;
    end_d    = end_q;
    origin_d = origin_q;
    dest_d   = dest_q;
    ts_d     = ts_q;

    sel_start = ptr_at(32'(grant));
    sel_limit = ptr_at(32'(grant) + 1);
    if (sel_limit > MaxConnPos) sel_limit = MaxConnPos;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StIntegrate;
          cyc_d   = '0;
        end
      end
      StIntegrate: begin
        if (enable) begin
          if (cyc_q == CycW'(TIMESTEP_CYCLES - 1)) begin
            cyc_d   = '0;
            state_d = StCapture;
          end else begin
            cyc_d = cyc_q + 1'b1;
          end
        end
      end
      StCapture: begin
        mask_d  = spike;
        ts_d    = ts_q + 16'd1;
        state_d = StSelect;
      end
      StSelect: begin
        if (!any_pending) begin
          state_d = StIntegrate;
          cyc_d   = '0;
        end else begin
          rr_d = (32'(grant) == NUM_NEURONS - 1) ? '0 : grant + 1'b1;
          if (sel_start >= sel_limit) begin
            // Empty or malformed range: retire the neuron without emitting.
            mask_d[grant] = 1'b0;
          end else begin
            state_d  = StEmit;
            cur_d    = grant;
            idx_d    = sel_start;
            end_d    = sel_limit;
            origin_d = addr_at(grant);
            dest_d   = entry_at(sel_start);
          end
        end
      end
      StEmit: begin
        if (pkt_ready) begin
          if (idx_q + 1'b1 >= end_q) begin
            mask_d[cur_q] = 1'b0;
            state_d       = StSelect;
          end else begin
            idx_d  = idx_q + 1'b1;
            dest_d = entry_at(idx_q + 1'b1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= StIdle;
      cyc_q    <= '0;
      mask_q   <= '0;
      rr_q     <= '0;
      cur_q    <= '0;
      idx_q    <= '0;
      end_q    <= '0;
      origin_q <= '0;
      dest_q   <= '0;
      ts_q     <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      mask_q   <= mask_d;
      rr_q     <= rr_d;
      cur_q    <= cur_d;
      idx_q    <= idx_d;
      end_q    <= end_d;
      origin_q <= origin_d;
      dest_q   <= dest_d;
      ts_q     <= ts_d;
    end
  end

  assign clear           = (state_q == StCapture);
  assign pkt_valid       = (state_q == StEmit);
  assign busy            = (state_q == StSelect) || (state_q == StEmit);
  assign pkt_origin      = origin_q;
  assign pkt_destination = dest_q;
  assign timestep_count  = ts_q;

endmodule

// File: tb/tb_spike_dispatch_scheduler.sv
// Scoreboard bench for spike_dispatch_scheduler: directed stimulus pushes
// expected packets; a negedge monitor pops and compares on each handshake.
module tb_spike_dispatch_scheduler;

  localparam int N  = 10;
  localparam int AW = 12;
  localparam int PW = 5;
  localparam int MC = 30;

  logic            CLK = 1'b0;
  logic            reset;
  logic            enable;
  logic            pkt_ready;
  logic [N-1:0]    spike;
  logic [N*AW-1:0] addrs;
  logic [(N+1)*PW-1:0] ptrs;
  logic [MC*AW-1:0]    conns;
  logic            clear;
  logic            pkt_valid;
  logic            busy;
  logic [AW-1:0]   pkt_origin;
  logic [AW-1:0]   pkt_destination;
  logic [15:0]     timestep_count;

  typedef struct packed {
    logic [AW-1:0] origin;
    logic [AW-1:0] dest;
  } pkt_t;

  pkt_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;

  int          ptr_tbl[11] = '{0, 3, 5, 8, 10, 12, 14, 15, 17, 18, 19};
  logic [11:0] ent_tbl[19] = '{12'h3, 12'h5, 12'h7, 12'h4, 12'h6, 12'h4, 12'h5, 12'h6,
                               12'h8, 12'h9, 12'h8, 12'h9, 12'h8, 12'h9, 12'h9, 12'h8,
                               12'h9, 12'hFFB, 12'hFFC};

  spike_dispatch_scheduler dut (
    .CLK                                   (CLK),
    .reset                                 (reset),
    .enable                                (enable),
    .spike                                 (spike),
    .neuron_addresses_initialization       (addrs),
    .connection_pointer_initialization     (ptrs),
    .downstream_connections_initialization (conns),
    .clear                                 (clear),
    .pkt_valid                             (pkt_valid),
    .pkt_ready                             (pkt_ready),
    .pkt_origin                            (pkt_origin),
    .pkt_destination                       (pkt_destination),
    .busy                                  (busy),
    .timestep_count                        (timestep_count)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_ptr(input int i, input int v);
    ptrs[(N - i) * PW +: PW] = PW'(v);
  endtask

  task automatic expect_pkt(input logic [AW-1:0] o, input logic [AW-1:0] d);
    pkt_t p;
    p.origin = o;
    p.dest   = d;
    exp_q.push_back(p);
  endtask

  // Advance at least one cycle, then until clear is seen (bounded).
  task automatic wait_clear(input string name, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!clear && waited < 100);
    if (!clear) begin
      total_cnt++;
      $display("FAIL %s: clear=0 after %0d cycles, required 1", name, waited);
    end
  endtask

  // Monitor: compare every accepted packet against the scoreboard.
  initial begin : monitor
    pkt_t e;
    forever begin
      @(negedge CLK);
      if (!reset && pkt_valid && pkt_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL pkt_unexpected: got (%0h,%0h) required no packet",
                   pkt_origin, pkt_destination);
        end else begin
          e = exp_q.pop_front();
          check("pkt_origin", 32'(pkt_origin), 32'(e.origin));
          check("pkt_destination", 32'(pkt_destination), 32'(e.dest));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no $finish within time limit, required finish");
    $fatal(1);
  end

  initial begin : stimulus
    int w;
    int t0;
    int stable;
    int n;

    addrs = '0;
    ptrs  = '0;
    conns = '0;
    for (int i = 0; i < N; i++) addrs[i * AW +: AW] = AW'(i);
    for (int i = 0; i <= N; i++) set_ptr(i, ptr_tbl[i]);
    for (int k = 0; k < 19; k++) conns[(MC - 1 - k) * AW +: AW] = ent_tbl[k];

    // Reset state
    reset = 1'b1; enable = 1'b0; spike = '0; pkt_ready = 1'b1;
    tick(); tick();
    check("rst_clear", 32'(clear), 0);
    check("rst_pkt_valid", 32'(pkt_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timestep_count", 32'(timestep_count), 0);
    check("rst_pkt_origin", 32'(pkt_origin), 0);
    check("rst_pkt_destination", 32'(pkt_destination), 0);

    // Idle timesteps: clear every 6 cycles, count increments per pulse
    reset = 1'b0; enable = 1'b1;
    wait_clear("first_clear", w);
    check("first_clear_latency", w, 5);
    check("ts_at_clear0", 32'(timestep_count), 0);
    t0 = cyc;
    tick();
    check("ts_after_clear0", 32'(timestep_count), 1);
    check("select_busy", 32'(busy), 1);
    wait_clear("idle_clear1", w);
    check("idle_period1", cyc - t0, 6);
    t0 = cyc;
    wait_clear("idle_clear2", w);
    check("idle_period2", cyc - t0, 6);
    check("ts_at_clear2", 32'(timestep_count), 2);

    // Neuron 0 fans out to 3 destinations back to back
    tick(); spike = 10'h001;
    expect_pkt(12'h0, 12'h3); expect_pkt(12'h0, 12'h5); expect_pkt(12'h0, 12'h7);
    wait_clear("t2_clear", w);
    t0 = cyc;
    tick(); spike = '0;
    check("t2_select_no_valid", 32'(pkt_valid), 0);
    tick();
    check("t2_valid_clear_plus2", 32'(pkt_valid), 1);
    tick(); tick();
    check("t2_third_valid", 32'(pkt_valid), 1);
    check("t2_third_dest", 32'(pkt_destination), 32'h7);
    tick();
    check("t2_valid_drops", 32'(pkt_valid), 0);
    wait_clear("t2_next", w);
    check("t2_period", cyc - t0, 10);
    check("t2_queue_drained", exp_q.size(), 0);

    // Backpressure: first packet held 5 cycles, rest follow in order
    tick(); spike = 10'h001; pkt_ready = 1'b0;
    expect_pkt(12'h0, 12'h3); expect_pkt(12'h0, 12'h5); expect_pkt(12'h0, 12'h7);
    wait_clear("t3_clear", w);
    tick(); spike = '0;
    tick();
    stable = 0;
    for (int s = 0; s < 5; s++) begin
      if (pkt_valid && pkt_origin == 12'h0 && pkt_destination == 12'h3) stable++;
      if (s < 4) tick();
    end
    pkt_ready = 1'b1;
    check("t3_held_cycles", stable, 5);
    tick();
    check("t3_second_dest", 32'(pkt_destination), 32'h5);
    tick();
    check("t3_third_dest", 32'(pkt_destination), 32'h7);
    tick();
    check("t3_valid_drops", 32'(pkt_valid), 0);
    check("t3_queue_drained", exp_q.size(), 0);

    // Two neurons: 8 before 9
    spike = 10'h300;
    expect_pkt(12'h8, 12'hFFB); expect_pkt(12'h9, 12'hFFC);
    wait_clear("t4_clear", w);
    tick(); spike = '0;
    tick();
    check("t4_first_origin", 32'(pkt_origin), 32'h8);
    wait_clear("t4_next", w);
    check("t4_queue_drained", exp_q.size(), 0);

    // Empty range for neuron 3 costs one SELECT cycle, no packets
    tick(); tick();
    set_ptr(4, 8);
    spike = 10'h008;
    wait_clear("t5_clear", w);
    t0 = cyc;
    tick(); spike = 10'h010;
    check("t5_select1_busy", 32'(busy), 1);
    tick();
    check("t5_select2_busy", 32'(busy), 1);
    check("t5_select2_no_valid", 32'(pkt_valid), 0);
    tick();
    check("t5_back_to_integrate", 32'(busy), 0);
    wait_clear("t5_next", w);
    check("t5_period", cyc - t0, 7);
    set_ptr(4, 10);
    expect_pkt(12'h4, 12'h8); expect_pkt(12'h4, 12'h9);
    t0 = cyc;
    tick(); spike = '0;
    tick();
    check("t5_n4_valid", 32'(pkt_valid), 1);
    check("t5_n4_origin", 32'(pkt_origin), 32'h4);
    wait_clear("t5_n4_next", w);
    check("t5_n4_period", cyc - t0, 9);
    check("t5_queue_drained", exp_q.size(), 0);

    // Reset during a stalled EMIT
    tick(); spike = 10'h001; pkt_ready = 1'b0;
    wait_clear("t6_clear", w);
    tick(); spike = '0;
    tick();
    check("t6_emit_stalled", 32'(pkt_valid), 1);
    reset = 1'b1;
    tick();
    check("t6_rst_valid", 32'(pkt_valid), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ts", 32'(timestep_count), 0);
    reset = 1'b0; enable = 1'b0;
    n = 0;
    repeat (8) begin
      tick();
      if (clear || busy || pkt_valid) n++;
    end
    check("t6_idle_quiet", n, 0);
    enable = 1'b1; pkt_ready = 1'b1;
    wait_clear("t6_restart", w);
    check("t6_restart_latency", w, 5);
    check("t6_restart_ts", 32'(timestep_count), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
